lat_memory: RTL and testbench
=============================

// Module: lat_memory
// PURPOSE
//  Parametrised line-granular backing-memory model for the cache subsystem; successor of the fixed 128-bit,
//  zero-wait memory. Adds programmable read/write latency, a valid/ready request handshake, byte-enabled
//  writes, defined reads of never-written lines, and out-of-range error reporting. Sits below the cache FSM.
// PARAMETERS
//  ADDR_W      32    byte-address width
//  LINE_W      128   line width in bits; power of two, >= 32
//  DEPTH       1024  lines stored; power of two
//  RD_LAT      4     cycles from request acceptance to read response; >= 1
//  WR_LAT      2     cycles from request acceptance to write acknowledge; >= 1
//  FILL        '0    LINE_W-bit value returned for a never-written line
// PORTS
//  clk_i        in   1          clock, all logic on rising edge
//  rst_i        in   1          asynchronous active-high reset
//  req_valid_i  in   1          request present
//  req_ready_o  out  1          block can accept a request this cycle
//  req_rw_i     in   1          1 = write, 0 = read
//  req_addr_i   in   ADDR_W     byte address; line index = addr >> log2(LINE_W/8)
//  req_be_i     in   LINE_W/8   write byte enables (ignored on read)
//  req_data_i   in   LINE_W     write data
//  rsp_valid_o  out  1          one-cycle response pulse (read data or write ack)
//  rsp_data_o   out  LINE_W     read data, valid while rsp_valid_o
//  rsp_err_o    out  1          out-of-range address, valid while rsp_valid_o
// BEHAVIOUR
//  Reset (async, rst_i=1): req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, state=IDLE, latency
//   counter=0, written-line bitmap cleared. Storage array itself is not reset; bitmap makes it read FILL.
//  Handshake: request accepted on rising edge where req_valid_i && req_ready_o. rw/addr/be/data captured
//   on acceptance; inputs ignored afterwards. One outstanding request; no pipelining.
//  FSM: IDLE -(accept)-> WAIT (cnt loaded with LAT-1, LAT=RD_LAT or WR_LAT) -(cnt==0)-> RESP -> IDLE.
//   WAIT decrements cnt each cycle. RESP lasts exactly one cycle, rsp_valid_o=1.
//   req_ready_o=1 only in IDLE (registered). Response asserts LAT cycles after the acceptance edge;
//   next request accepted no earlier than the cycle after RESP (throughput 1 per LAT+2 cycles).
//  Line index: addr >> log2(LINE_W/8); low offset bits ignored. Index >= DEPTH, or nonzero upper bits
//   above log2(DEPTH), => out of range: no storage access, rsp_err_o=1, rsp_data_o=0, same latency.
//  Write: performed in the RESP cycle; byte k of line updated iff req_be_i[k]; bitmap bit set. Partial
//   write to never-written line: unmasked bytes take FILL. be=0 write: no change, bitmap unchanged, ack given.
//  Read: rsp_data_o = bitmap ? stored line : FILL. Read-after-write to same line returns new data.
//  rsp_data_o holds last value outside RESP; rsp_err_o=0 except in an erroring RESP.
//  Reset mid-operation: transaction dropped, no response, no write committed; IDLE after deassert.
// STRUCTURE
//  cache_def package gains: mem_lat_req_t / mem_lat_rsp_t structs (parametrised via LINE_W/ADDR_W
//   localparams), lat_state_e enum {IDLE, WAIT, RESP}.
//  One sub-module: lat_mem_array (DEPTH x LINE_W byte-enabled storage + valid bitmap, sync write,
//   comb read). Control FSM and counter stay in lat_memory.
// TESTING
//  Reset, then read addr 0x40 -> after RD_LAT=4 cycles rsp_valid_o=1, rsp_data_o=FILL, rsp_err_o=0.
//  Write addr 0x40 data 0xDEADBEEF_..._01, be all-ones -> ack after 2 cycles; read 0x4C -> same line.
//  Write be=16'h0001 data byte 0xAA to 0x80 (unwritten) -> read returns FILL with byte0=0xAA.
//  Read addr DEPTH*16 -> rsp_err_o=1, rsp_data_o=0 after 4 cycles; storage unchanged.
//  Hold req_valid_i=1 continuously -> req_ready_o low from accept through RESP; accepts 1 per LAT+2.
//  Assert rst_i during WAIT of a write -> no rsp_valid_o; subsequent read returns prior contents.

Source files
------------

// File: rtl/cache_def.sv
// Shared types for the cache subsystem: latency-memory request/response structs and FSM states.
package cache_def;

   localparam int MEM_LINE_W = 128;
   localparam int MEM_ADDR_W = 32;
   localparam int MEM_BE_W   = MEM_LINE_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } lat_state_e;

   typedef struct packed {
      logic                  rw;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_BE_W-1:0]   be;
      logic [MEM_LINE_W-1:0] data;
   } mem_lat_req_t;

   typedef struct packed {
      logic                  valid;
      logic                  err;
      logic [MEM_LINE_W-1:0] data;
   } mem_lat_rsp_t;

endpackage

// File: rtl/lat_mem_array.sv
// Line storage with per-byte write enables and a written-line bitmap; lines never written read as FILL.
module lat_mem_array #(
   parameter int                LINE_W = 128,
   parameter int                DEPTH  = 1024,
   parameter logic [LINE_W-1:0] FILL   = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   idx_i,
   input  logic [LINE_W/8-1:0]        be_i,
   input  logic [LINE_W-1:0]          wdata_i,
   output logic [LINE_W-1:0]          rdata_o
);

   localparam int BE_W = LINE_W / 8;

   logic [LINE_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;
   logic [DEPTH-1:0]  vld_d;
   logic [LINE_W-1:0] base_line;
   logic [LINE_W-1:0] wr_line;
   logic              wr_en;

   assign wr_en = we_i && (|be_i);

   // Unmasked bytes of a partial write keep the current visible value, which is FILL for a fresh line.
   always_comb begin
      base_line = vld_q[idx_i] ? mem_q[idx_i] : FILL;
      wr_line   = base_line;
      for (int k = 0; k < BE_W; k++) begin
         if (be_i[k]) wr_line[8*k +: 8] = wdata_i[8*k +: 8];
      end
      vld_d = vld_q;
      if (wr_en) vld_d[idx_i] = 1'b1;
   end

   assign rdata_o = base_line;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) vld_q <= '0;
      else       vld_q <= vld_d;
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[idx_i] <= wr_line;
   end

endmodule

// File: rtl/lat_memory.sv
// Line-granular backing memory with programmable read/write latency and a single-outstanding handshake.
//  state | meaning
//  IDLE  | ready for a request, req_ready_o high
//  WAIT  | request captured, counting down the latency
//  RESP  | one-cycle response pulse; a write commits here
module lat_memory
   import cache_def::*;
#(
   parameter int                ADDR_W = 32,
   parameter int                LINE_W = 128,
   parameter int                DEPTH  = 1024,
   parameter int                RD_LAT = 4,
   parameter int                WR_LAT = 2,
   parameter logic [LINE_W-1:0] FILL   = '0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_rw_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [LINE_W/8-1:0] req_be_i,
   input  logic [LINE_W-1:0]   req_data_i,
   output logic                rsp_valid_o,
   output logic [LINE_W-1:0]   rsp_data_o,
   output logic                rsp_err_o
);

   localparam int BE_W    = LINE_W / 8;
   localparam int OFF_W   = $clog2(BE_W);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

   lat_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rdy_q, rdy_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [LINE_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rw_q, rw_d;
   logic              err_q, err_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic [LINE_W-1:0] rd_data;
   logic              mem_we;
   logic              unused_addr_off;

   assign unused_addr_off = ^req_addr_i[OFF_W-1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdy_d       = rdy_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = 1'b0;
      rw_d        = rw_q;
      err_d       = err_q;
      idx_d       = idx_q;
      be_d        = be_q;
      data_d      = data_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i && rdy_q) begin
               state_d = WAIT;
               rdy_d   = 1'b0;
               rw_d    = req_rw_i;
               idx_d   = req_addr_i[OFF_W +: IDX_W];
               // Any set bit above the index field puts the line beyond DEPTH.
               err_d   = |(req_addr_i >> (OFF_W + IDX_W));
               be_d    = req_be_i;
               data_d  = req_data_i;
               cnt_d   = req_rw_i ? WR_LOAD : RD_LOAD;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               if (err_q)      rsp_data_d = '0;
               else if (!rw_q) rsp_data_d = rd_data;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            rdy_d   = 1'b1;
         end
         default: begin
            state_d = IDLE;
            rdy_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rdy_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rw_q        <= 1'b0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         be_q        <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rdy_q       <= rdy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rw_q        <= rw_d;
         err_q       <= err_d;
         idx_q       <= idx_d;
         be_q        <= be_d;
         data_q      <= data_d;
      end
   end

   assign mem_we = (state_q == RESP) && rw_q && !err_q;

   lat_mem_array #(
      .LINE_W (LINE_W),
      .DEPTH  (DEPTH),
      .FILL   (FILL)
   ) u_array (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (mem_we),
      .idx_i   (idx_q),
      .be_i    (be_q),
      .wdata_i (data_q),
      .rdata_o (rd_data)
   );

   assign req_ready_o = rdy_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_lat_memory.sv
// Directed and randomized checks of lat_memory against an array-based reference memory.
module tb_lat_memory;

   localparam int LINES  = 1024;
   localparam int RD_LAT = 4;
   localparam int WR_LAT = 2;
   localparam logic [127:0] FILL = '0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_rw = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [15:0]  req_be = '0;
   logic [127:0] req_data = '0;
   logic         rsp_valid;
   logic [127:0] rsp_data;
   logic         rsp_err;

   int checks = 0;
   int errors = 0;

   logic [127:0] mem_m [LINES];
   bit           wr_m  [LINES];

   always #5 clk = ~clk;

   lat_memory dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_rw_i    (req_rw),
      .req_addr_i  (req_addr),
      .req_be_i    (req_be),
      .req_data_i  (req_data),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .rsp_err_o   (rsp_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) wr_m[i] = 1'b0;
   endtask

   function automatic logic [127:0] model_line(input int idx);
      return wr_m[idx] ? mem_m[idx] : FILL;
   endfunction

   // Issue one request, time the response and compare it with the reference memory.
   task automatic do_req(input string tag, input logic rw, input logic [31:0] addr,
                         input logic [15:0] be, input logic [127:0] data);
      int           n;
      int           lat;
      bit           oor;
      int           idx;
      bit           rdy_seen;
      logic [127:0] exp_d;
      logic [127:0] line;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_ready"}, {127'd0, req_ready}, 128'd1);
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_be    = be;
      req_data  = data;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_rw    = ~rw;
      req_addr  = $urandom;
      req_be    = 16'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      lat      = rw ? WR_LAT : RD_LAT;
      oor      = (addr / 16) >= LINES;
      idx      = oor ? 0 : int'(addr / 16);
      n        = 0;
      rdy_seen = 1'b0;
      do begin
         if (req_ready) rdy_seen = 1'b1;
         @(posedge clk); #1;
         n++;
      end while (!rsp_valid && n < lat + 6);
      if (req_ready) rdy_seen = 1'b1;
      chk({tag, "_lat"}, 128'(n), 128'(lat));
      chk({tag, "_busy"}, {127'd0, rdy_seen}, 128'd0);
      chk({tag, "_err"}, {127'd0, rsp_err}, {127'd0, oor});
      if (oor) begin
         chk({tag, "_oordata"}, rsp_data, 128'd0);
      end else if (!rw) begin
         exp_d = model_line(idx);
         chk({tag, "_rdata"}, rsp_data, exp_d);
      end
      if (rw && !oor && be != 16'd0) begin
         line = model_line(idx);
         for (int k = 0; k < 16; k++) if (be[k]) line[8*k +: 8] = data[8*k +: 8];
         mem_m[idx] = line;
         wr_m[idx]  = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {127'd0, rsp_valid}, 128'd0);
      chk({tag, "_errclr"}, {127'd0, rsp_err}, 128'd0);
   endtask

   initial begin
      int           acc;
      int           pulses;
      int           win;
      logic [127:0] wdata;
      logic [31:0]  raddr;

      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {127'd0, req_ready}, 128'd1);
      chk("rst_valid", {127'd0, rsp_valid}, 128'd0);
      chk("rst_data", rsp_data, 128'd0);
      chk("rst_err", {127'd0, rsp_err}, 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_req("rd_fresh", 1'b0, 32'h40, 16'h0000, 128'd0);
      wdata = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
      do_req("wr_full", 1'b1, 32'h40, 16'hFFFF, wdata);
      do_req("rd_offset", 1'b0, 32'h4C, 16'h0000, 128'd0);
      do_req("wr_byte0", 1'b1, 32'h80, 16'h0001, 128'hAA);
      do_req("rd_byte0", 1'b0, 32'h80, 16'h0000, 128'd0);
      do_req("wr_be0", 1'b1, 32'h40, 16'h0000, ~wdata);
      do_req("rd_be0", 1'b0, 32'h40, 16'h0000, 128'd0);
      do_req("rd_oor", 1'b0, LINES * 16, 16'h0000, 128'd0);
      do_req("wr_oor", 1'b1, LINES * 16, 16'hFFFF, ~wdata);
      do_req("rd_alias", 1'b0, 32'h0, 16'h0000, 128'd0);
      do_req("rd_hi", 1'b0, 32'h8000_0040, 16'h0000, 128'd0);

      // Back-to-back reads with valid held high: one accept per RD_LAT+2 cycles.
      win       = 3 * (RD_LAT + 2);
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = 32'h40;
      acc       = 0;
      pulses    = 0;
      for (int i = 0; i < win; i++) begin
         if (req_ready) acc++;
         if (rsp_valid) pulses++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("hold_accepts", 128'(acc), 128'(win / (RD_LAT + 2)));
      chk("hold_rsps", 128'(pulses), 128'(win / (RD_LAT + 2)));
      chk("hold_data", rsp_data, model_line(4));

      // Reset while a write is waiting: nothing responds and nothing commits.
      while (!req_ready) begin
         @(posedge clk); #1;
      end
      req_valid = 1'b1;
      req_rw    = 1'b1;
      req_addr  = 32'h100;
      req_be    = 16'hFFFF;
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_ready", {127'd0, req_ready}, 128'd1);
      chk("midrst_valid", {127'd0, rsp_valid}, 128'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) pulses++;
         @(posedge clk); #1;
      end
      chk("midrst_norsp", 128'(pulses), 128'd0);
      do_req("midrst_rd", 1'b0, 32'h100, 16'h0000, 128'd0);
      do_req("midrst_rd40", 1'b0, 32'h40, 16'h0000, 128'd0);

      for (int t = 0; t < 40; t++) begin
         raddr = 32'($urandom_range(0, 7)) * 16 + 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) raddr = raddr + 32'(LINES * 16);
         do_req("rand", 1'($urandom_range(0, 1)), raddr, 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom});
      end
      for (int l = 0; l < 8; l++) do_req("sweep", 1'b0, 32'(l * 16), 16'h0000, 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
